token_concat_mover: RTL
=======================

Name: token_concat_mover

Overview:
- Generalised width-axis concatenation engine for the accelerator datapath.
- Builds out[cg][h][0..WA+WB-1] from source A (WA tokens) followed by source B (WB tokens), for every Tout channel group and every line.
- Supports an arbitrary prefix length WA, independent per-source strides, and stride-0 broadcast of A, e.g. one class token prepended to every line.
- Sits between the CSR-configured layer sequencer and the AXI read/write masters; moves one pixel word (Tout*MAX_DAT_DW*Tb bits) per transaction, strictly in order.

Parameters:
- PIX_DW, 256: pixel word width in bits. PIX_BYTES = PIX_DW/8.
- ADDR_W, 32: byte address width.
- CNT_W, 16: width of the token, line and channel-group counters.
- DEPTH, 8: maximum outstanding reads, equal to the write-address FIFO depth. Power of 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle launch; config is sampled on this cycle.
- cfg_wa  in  CNT_W  tokens taken from A per line.
- cfg_wb  in  CNT_W  tokens taken from B per line.
- cfg_h  in  CNT_W  number of lines.
- cfg_cg  in  CNT_W  number of channel groups (CH/Tout).
- cfg_a_base, cfg_a_surf, cfg_a_line  in  ADDR_W  A base address, surface stride, line stride. A stride of 0 is legal and means broadcast.
- cfg_b_base, cfg_b_surf, cfg_b_line  in  ADDR_W  B base address, surface stride, line stride.
- cfg_o_base, cfg_o_surf, cfg_o_line  in  ADDR_W  output base address, surface stride, line stride.
- rd_req_valid  out  1; rd_req_ready  in  1; rd_req_addr  out  ADDR_W  read request channel.
- rd_dat_valid  in  1; rd_dat_ready  out  1; rd_dat  in  PIX_DW  in-order read data channel.
- wr_valid  out  1; wr_ready  in  1; wr_addr  out  ADDR_W; wr_data  out  PIX_DW  write channel.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, FIFO empty. Reset asserted mid-operation aborts immediately with no further requests; in-flight data is discarded.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE -> ISSUE on start, when total = (wa+wb)*h*cg > 0.
  - IDLE -> FIN on start when wa+wb == 0, h == 0 or cg == 0. No transactions are generated.
  - ISSUE -> DRAIN on the handshake of the last read request.
  - DRAIN -> FIN when the outstanding count reaches 0.
  - FIN -> IDLE after one cycle, with done = 1 during FIN.
- busy = 1 in ISSUE and DRAIN. A start arriving outside IDLE is ignored.
- All cfg_* inputs are registered on start; later changes to them have no effect on the running operation.
- Loop order, innermost first: w in 0..wa+wb-1, then h in 0..h-1, then cg in 0..cg-1.
- Read address:
  - w < wa: a_base + cg*a_surf + h*a_line + w*PIX_BYTES.
  - otherwise: b_base + cg*b_surf + h*b_line + (w-wa)*PIX_BYTES.
- Output address: o_base + cg*o_surf + h*o_line + w*PIX_BYTES.
- Address arithmetic is modulo 2^ADDR_W. Addresses are computed incrementally with running-sum registers; no multipliers are used.
- rd_req_valid is asserted in ISSUE only while outstanding < DEPTH. rd_req_addr and rd_req_valid stay stable until the handshake completes.
- On each read-request handshake the matching output address is pushed into the write-address FIFO, and the loop counters advance.
- Write channel: wr_valid = rd_dat_valid & FIFO non-empty. wr_data = rd_dat and wr_addr = FIFO head, both combinational.
- rd_dat_ready = wr_ready & FIFO non-empty. The FIFO pops on the write handshake.
- Outstanding counter: +1 on a read-request handshake, -1 on a write handshake. Both in the same cycle leave it unchanged. It never exceeds DEPTH.
- rd_dat_valid arriving while the FIFO is empty is a protocol error: the data is not accepted (ready = 0).
- Exact transaction counts: total read requests = total writes = (wa+wb)*h*cg. done follows the last write handshake by exactly 1 cycle.

Test Plan:
- Class-token prepend: wa=1, a_surf=a_line=0, wb=16, h=1, cg=2, PIX_BYTES=32, o_surf=17*32 -> 34 writes. Writes 0 and 17 read address a_base; write 1 reads b_base; write 18 reads b_base+b_surf. Output address of write 18 is o_base+544+32. done occurs once.
- Pure copy: wa=0, wb=4, h=2, cg=1 -> 8 writes. Write i reads b_base + (i/4)*b_line + (i%4)*32 and writes the matching o address. Data matches bit-exact.
- Backpressure: wr_ready toggles 1,0,0,1 repeatedly -> no write is lost or duplicated; outstanding ≤ 8; final write count equals the expected total.
- Read stall: rd_dat_valid held at 0 for 50 cycles -> exactly 8 read requests are accepted, then rd_req_valid stays low until data resumes.
- Zero size: start with h=0 -> done on the cycle after start, busy stays 0 throughout, no requests issued. A second start pulse during a busy run is ignored: transaction count unchanged.
- Reset mid-run: rst_n pulled low after 5 writes -> all outputs 0 on the same edge. A subsequent start runs a complete fresh operation.

Source files
------------

// File: rtl/token_concat_mover.sv
// Width-axis concatenation mover: per channel group and line, streams A[0..wa) then
// B[0..wb) into the output tensor, one pixel word per in-order read/write transaction.
module token_concat_mover #(
    parameter int unsigned PIX_DW = 256,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_wa,
    input  logic [CNT_W-1:0]  cfg_wb,
    input  logic [CNT_W-1:0]  cfg_h,
    input  logic [CNT_W-1:0]  cfg_cg,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_a_surf,
    input  logic [ADDR_W-1:0] cfg_a_line,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic [ADDR_W-1:0] cfg_b_surf,
    input  logic [ADDR_W-1:0] cfg_b_line,
    input  logic [ADDR_W-1:0] cfg_o_base,
    input  logic [ADDR_W-1:0] cfg_o_surf,
    input  logic [ADDR_W-1:0] cfg_o_line,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_dat_valid,
    output logic              rd_dat_ready,
    input  logic [PIX_DW-1:0] rd_dat,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_DW-1:0] wr_data,
    output logic              busy,
    output logic              done
);
    localparam int unsigned PIX_BYTES = PIX_DW / 8;
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W     = $clog2(DEPTH + 1);
    localparam int unsigned W_W       = CNT_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [OCC_W-1:0]  outstanding, outstanding_nxt;
    logic [CNT_W-1:0]  wa_q, h_q, cg_q, h_cnt, cg_cnt;
    logic [W_W-1:0]    wlen_q, w_cnt, cfg_wlen;
    logic [ADDR_W-1:0] a_surf_q, a_line_q, b_surf_q, b_line_q, o_surf_q, o_line_q;
    logic [ADDR_W-1:0] a_cg, a_row, b_cg, b_row, o_cg, o_row, o_ptr;
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              start_acc, zero_size, fifo_nonempty, rd_hs, wr_hs;
    logic              last_w, last_h, last_cg, last_req;

    assign cfg_wlen      = W_W'(cfg_wa) + W_W'(cfg_wb);
    assign zero_size     = (cfg_wlen == '0) || (cfg_h == '0) || (cfg_cg == '0);
    assign start_acc     = start && (state == S_IDLE);
    assign fifo_nonempty = (outstanding != '0);
    assign rd_hs         = rd_req_valid && rd_req_ready;
    assign wr_valid      = rd_dat_valid && fifo_nonempty;
    assign rd_dat_ready  = wr_ready && fifo_nonempty;
    assign wr_hs         = wr_valid && wr_ready;
    // Head-of-FIFO address and data are forced to 0 while nothing is outstanding.
    assign wr_addr       = fifo_nonempty ? mem[rd_ptr] : '0;
    assign wr_data       = fifo_nonempty ? rd_dat : '0;

    assign last_w   = (w_cnt == wlen_q - W_W'(1));
    assign last_h   = (h_cnt == h_q - CNT_W'(1));
    assign last_cg  = (cg_cnt == cg_q - CNT_W'(1));
    assign last_req = last_w && last_h && last_cg;

    always_comb begin
        outstanding_nxt = outstanding;
        if (rd_hs && !wr_hs) begin
            outstanding_nxt = outstanding + OCC_W'(1);
        end else if (!rd_hs && wr_hs) begin
            outstanding_nxt = outstanding - OCC_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = zero_size ? S_FIN : S_ISSUE;
            S_ISSUE: if (rd_hs && last_req) state_nxt = S_DRAIN;
            S_DRAIN: if (outstanding_nxt == '0) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Status/handshake outputs are registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_req_valid <= 1'b0;
            outstanding  <= '0;
        end else begin
            busy         <= (state_nxt == S_ISSUE) || (state_nxt == S_DRAIN);
            done         <= (state_nxt == S_FIN);
            rd_req_valid <= (state_nxt == S_ISSUE) && (outstanding_nxt < OCC_W'(DEPTH));
            outstanding  <= outstanding_nxt;
        end
    end

    // Loop counters and running-sum address generators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_q <= '0; wlen_q <= '0; h_q <= '0; cg_q <= '0;
            a_surf_q <= '0; a_line_q <= '0; b_surf_q <= '0; b_line_q <= '0;
            o_surf_q <= '0; o_line_q <= '0;
            w_cnt <= '0; h_cnt <= '0; cg_cnt <= '0;
            a_cg <= '0; a_row <= '0; b_cg <= '0; b_row <= '0;
            o_cg <= '0; o_row <= '0; o_ptr <= '0;
            rd_req_addr <= '0;
        end else if (start_acc) begin
            wa_q <= cfg_wa; wlen_q <= cfg_wlen; h_q <= cfg_h; cg_q <= cfg_cg;
            a_surf_q <= cfg_a_surf; a_line_q <= cfg_a_line;
            b_surf_q <= cfg_b_surf; b_line_q <= cfg_b_line;
            o_surf_q <= cfg_o_surf; o_line_q <= cfg_o_line;
            w_cnt <= '0; h_cnt <= '0; cg_cnt <= '0;
            a_cg <= cfg_a_base; a_row <= cfg_a_base;
            b_cg <= cfg_b_base; b_row <= cfg_b_base;
            o_cg <= cfg_o_base; o_row <= cfg_o_base; o_ptr <= cfg_o_base;
            rd_req_addr <= (cfg_wa != '0) ? cfg_a_base : cfg_b_base;
        end else if (rd_hs) begin
            if (!last_w) begin
                w_cnt <= w_cnt + W_W'(1);
                o_ptr <= o_ptr + ADDR_W'(PIX_BYTES);
                // Crossing from the A prefix into B restarts at the B line base.
                if (w_cnt + W_W'(1) == W_W'(wa_q)) begin
                    rd_req_addr <= b_row;
                end else begin
                    rd_req_addr <= rd_req_addr + ADDR_W'(PIX_BYTES);
                end
            end else if (!last_h) begin
                w_cnt <= '0;
                h_cnt <= h_cnt + CNT_W'(1);
                a_row <= a_row + a_line_q;
                b_row <= b_row + b_line_q;
                o_row <= o_row + o_line_q;
                o_ptr <= o_row + o_line_q;
                rd_req_addr <= (wa_q != '0) ? (a_row + a_line_q) : (b_row + b_line_q);
            end else begin
                w_cnt  <= '0;
                h_cnt  <= '0;
                cg_cnt <= cg_cnt + CNT_W'(1);
                a_cg  <= a_cg + a_surf_q;
                a_row <= a_cg + a_surf_q;
                b_cg  <= b_cg + b_surf_q;
                b_row <= b_cg + b_surf_q;
                o_cg  <= o_cg + o_surf_q;
                o_row <= o_cg + o_surf_q;
                o_ptr <= o_cg + o_surf_q;
                rd_req_addr <= (wa_q != '0) ? (a_cg + a_surf_q) : (b_cg + b_surf_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rd_hs) wr_ptr <= wr_ptr + PTR_W'(1);
            if (wr_hs) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_hs) mem[wr_ptr] <= o_ptr;
    end
endmodule
